// File: rtl/proc_param_if.sv
// Bus/handshake bundle for proc_param: instruction/immediate in, run request, done, bus, zero flag.
// master = instruction source / observer, slave = processor.
interface proc_param_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] DIN;
    logic             Run;
    logic             Done;
    logic [WIDTH-1:0] BusWires;
    logic             Zflag;

    modport master (
        output DIN,
        output Run,
        input  Done,
        input  BusWires,
        input  Zflag
    );

    modport slave (
        input  DIN,
        input  Run,
        output Done,
        output BusWires,
        output Zflag
    );
endinterface

// File: rtl/proc_param.sv
// Parametrised multicycle bus processor: mv/mvi/add/sub/and/or/mvnz/nop over a shared bus.
// Define PROC_PARAM_MVNZ_EN to enable the conditional move (opcode 110); otherwise it is a nop.
module proc_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input logic         Clock,
    input logic         Reset,
    proc_param_if.slave bus
);
    localparam int unsigned RB = $clog2(NREG);
    localparam int unsigned IW = 3 + 2 * RB;

    typedef enum logic [1:0] {StT0, StT1, StT2, StT3} step_e;
    typedef enum logic [2:0] {
        OpMv, OpMvi, OpAdd, OpSub, OpAnd, OpOr, OpMvnz, OpNop
    } op_e;

    step_e            step_q, step_d;
    logic [IW-1:0]    ir_q;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] a_q, g_q;
    logic             z_q;

    op_e           op;
    logic [RB-1:0] rx, ry;
    logic          is_alu;

    assign op     = op_e'(ir_q[IW-1 -: 3]);
    assign rx     = ir_q[2*RB-1 -: RB];
    assign ry     = ir_q[RB-1:0];
    assign is_alu = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr);

    logic [NREG-1:0]  sel_r;
    logic             sel_din, sel_g;
    logic             rx_wr, a_wr, g_wr, done;
    logic [WIDTH-1:0] bus_w, alu_res;

    // Step decode: bus source selects and write enables.
    always_comb begin
        sel_r   = '0;
        sel_din = 1'b0;
        sel_g   = 1'b0;
        rx_wr   = 1'b0;
        a_wr    = 1'b0;
        g_wr    = 1'b0;
        done    = 1'b0;
        unique case (step_q)
            StT1: begin
                unique case (op)
                    OpMv: begin
                        sel_r[ry] = 1'b1;
                        rx_wr     = 1'b1;
                        done      = 1'b1;
                    end
                    OpMvi: begin
                        sel_din = 1'b1;
                        rx_wr   = 1'b1;
                        done    = 1'b1;
                    end
                    OpAdd, OpSub, OpAnd, OpOr: begin
                        sel_r[rx] = 1'b1;
                        a_wr      = 1'b1;
                    end
                    OpMvnz: begin
`ifdef PROC_PARAM_MVNZ_EN
                        sel_r[ry] = 1'b1;
                        rx_wr     = ~z_q;
`endif
                        done = 1'b1;
                    end
                    OpNop: done = 1'b1;
                endcase
            end
            StT2: begin
                sel_r[ry] = 1'b1;
                g_wr      = 1'b1;
            end
            StT3: begin
                sel_g = 1'b1;
                rx_wr = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    // AND-OR mux: selects are one-hot, so an idle bus reads zero.
    always_comb begin
        bus_w = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (sel_r[i]) bus_w = bus_w | regs_q[i];
        end
        if (sel_din) bus_w = bus_w | bus.DIN;
        if (sel_g) bus_w = bus_w | g_q;
    end

    always_comb begin
        unique case (op)
            OpAdd:   alu_res = a_q + bus_w;
            OpSub:   alu_res = a_q - bus_w;
            OpAnd:   alu_res = a_q & bus_w;
            OpOr:    alu_res = a_q | bus_w;
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        step_d = StT0;
        unique case (step_q)
            StT0: step_d = bus.Run ? StT1 : StT0;
            StT1: step_d = is_alu ? StT2 : StT0;
            StT2: step_d = StT3;
            StT3: step_d = StT0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_q <= StT0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            z_q    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            step_q <= step_d;
            if (step_q == StT0 && bus.Run) ir_q <= bus.DIN[IW-1:0];
            if (rx_wr) regs_q[rx] <= bus_w;
            if (a_wr) a_q <= bus_w;
            if (g_wr) begin
                g_q <= alu_res;
                z_q <= (alu_res == '0);
            end
        end
    end

    assign bus.BusWires = bus_w;
    assign bus.Done     = done;
    assign bus.Zflag    = z_q;
endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param: directed table, random program vs. ISA-level model,
// mid-instruction reset, and a 32-bit/16-register instance.
module tb_proc_param;
    localparam int unsigned W  = 16;
    localparam int unsigned N  = 8;
    localparam int unsigned W2 = 32;
    localparam int unsigned N2 = 16;
`ifdef PROC_PARAM_MVNZ_EN
    localparam bit MvnzEn = 1'b1;
`else
    localparam bit MvnzEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_param_if #(.WIDTH(W))  pif ();
    proc_param_if #(.WIDTH(W2)) pif2 ();

    proc_param #(.WIDTH(W), .NREG(N)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (pif)
    );

    proc_param #(.WIDTH(W2), .NREG(N2)) dut2 (
        .Clock(clk),
        .Reset(rst),
        .bus  (pif2)
    );

    int errors = 0;
    int checks = 0;

    // ISA-level state: architectural registers and zero flag only.
    logic [W-1:0] mr [N];
    logic         mz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mr[i] = '0;
        mz = 1'b0;
    endtask

    // Each cycle starts 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pif.Run = 1'b0;
            pif.DIN = W'($urandom);
            #1;
            check("idle done", 64'(pif.Done), 64'd0);
            check("idle bus", 64'(pif.BusWires), 64'd0);
            next_cycle();
        end
    endtask

    task automatic exec(input logic [2:0] op, input int x, input int y, input logic [W-1:0] imm,
                        output logic [W-1:0] last_bus);
        logic [W-1:0] exp_bus [3];
        logic [W-1:0] din, res, wval;
        logic         wr, is_alu;
        int           len;
        is_alu = (op >= 3'd2) && (op <= 3'd5);
        len = is_alu ? 3 : 1;
        res = alu(op, mr[x], mr[y]);
        exp_bus[1] = mr[y];
        exp_bus[2] = res;
        wr = 1'b0;
        wval = '0;
        case (op)
            3'd0: begin exp_bus[0] = mr[y]; wr = 1'b1; wval = mr[y]; end
            3'd1: begin exp_bus[0] = imm; wr = 1'b1; wval = imm; end
            3'd6: begin
                exp_bus[0] = MvnzEn ? mr[y] : '0;
                wr = MvnzEn && !mz;
                wval = mr[y];
            end
            3'd7: exp_bus[0] = '0;
            default: begin exp_bus[0] = mr[x]; wr = 1'b1; wval = res; end
        endcase
        din = W'($urandom);
        din[8:0] = {op, x[2:0], y[2:0]};
        pif.Run = 1'b1;
        pif.DIN = din;
        #1;
        check($sformatf("op%0d t0 done", op), 64'(pif.Done), 64'd0);
        check($sformatf("op%0d t0 bus", op), 64'(pif.BusWires), 64'd0);
        next_cycle();
        last_bus = '0;
        for (int k = 0; k < len; k++) begin
            pif.Run = 1'($urandom);
            pif.DIN = (op == 3'd1) ? imm : W'($urandom);
            if (is_alu && k == len - 1) mz = (res == '0);
            #1;
            check($sformatf("op%0d c%0d done", op, k), 64'(pif.Done), 64'(k == len - 1));
            check($sformatf("op%0d c%0d bus", op, k), 64'(pif.BusWires), 64'(exp_bus[k]));
            if (k == 0 || k == len - 1)
                check($sformatf("op%0d c%0d zflag", op, k), 64'(pif.Zflag), 64'(mz));
            last_bus = pif.BusWires;
            next_cycle();
        end
        if (wr) mr[x] = wval;
    endtask

    task automatic exec2(input logic [2:0] op, input int x, input int y, input logic [W2-1:0] imm,
                         input int len, input logic [W2-1:0] exp_last, input string name);
        logic [W2-1:0] din;
        din = W2'($urandom);
        din[10:0] = {op, x[3:0], y[3:0]};
        pif2.Run = 1'b1;
        pif2.DIN = din;
        #1;
        check({name, " t0 done"}, 64'(pif2.Done), 64'd0);
        next_cycle();
        for (int k = 0; k < len; k++) begin
            pif2.Run = 1'b0;
            pif2.DIN = (op == 3'd1) ? imm : W2'($urandom);
            #1;
            check($sformatf("%s c%0d done", name, k), 64'(pif2.Done), 64'(k == len - 1));
            if (k == len - 1) check({name, " bus"}, 64'(pif2.BusWires), 64'(exp_last));
            next_cycle();
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        int           x;
        int           y;
        logic [W-1:0] imm;
        logic [W-1:0] exp_bus;
        logic         exp_z;
    } vec_t;

    initial begin
        vec_t         tbl [19];
        logic [W-1:0] lb;
        time          t_start;

        tbl[0]  = '{3'd1, 0, 0, 16'h0005, 16'h0005, 1'b0};
        tbl[1]  = '{3'd0, 1, 0, 16'h0000, 16'h0005, 1'b0};
        tbl[2]  = '{3'd1, 0, 0, 16'hFFFF, 16'hFFFF, 1'b0};
        tbl[3]  = '{3'd1, 1, 0, 16'h0001, 16'h0001, 1'b0};
        tbl[4]  = '{3'd2, 0, 1, 16'h0000, 16'h0000, 1'b1};
        tbl[5]  = '{3'd1, 1, 0, 16'h0007, 16'h0007, 1'b1};
        tbl[6]  = '{3'd3, 1, 1, 16'h0000, 16'h0000, 1'b1};
        tbl[7]  = '{3'd1, 2, 0, 16'h00F0, 16'h00F0, 1'b1};
        tbl[8]  = '{3'd1, 3, 0, 16'h0F0F, 16'h0F0F, 1'b1};
        tbl[9]  = '{3'd4, 2, 3, 16'h0000, 16'h0000, 1'b1};
        tbl[10] = '{3'd1, 3, 0, 16'h1234, 16'h1234, 1'b1};
        tbl[11] = '{3'd6, 2, 3, 16'h0000, MvnzEn ? 16'h1234 : 16'h0000, 1'b1};
        tbl[12] = '{3'd0, 2, 2, 16'h0000, 16'h0000, 1'b1};
        tbl[13] = '{3'd5, 4, 3, 16'h0000, 16'h1234, 1'b0};
        tbl[14] = '{3'd6, 2, 3, 16'h0000, MvnzEn ? 16'h1234 : 16'h0000, 1'b0};
        tbl[15] = '{3'd0, 2, 2, 16'h0000, MvnzEn ? 16'h1234 : 16'h0000, 1'b0};
        tbl[16] = '{3'd1, 5, 0, 16'h4000, 16'h4000, 1'b0};
        tbl[17] = '{3'd2, 5, 5, 16'h0000, 16'h8000, 1'b0};
        tbl[18] = '{3'd7, 0, 0, 16'h0000, 16'h0000, 1'b0};

        model_reset();
        pif.Run  = 1'b1;
        pif.DIN  = 16'h0041;
        pif2.Run = 1'b0;
        pif2.DIN = '0;

        // Reset held with Run high.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("rst done", 64'(pif.Done), 64'd0);
            check("rst bus", 64'(pif.BusWires), 64'd0);
            check("rst zflag", 64'(pif.Zflag), 64'd0);
        end
        rst = 1'b0;
        idle(3);
        for (int k = 0; k < N; k++) exec(3'd0, k, k, '0, lb);

        for (int i = 0; i < 19; i++) begin
            exec(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].imm, lb);
            check($sformatf("vec%0d bus", i), 64'(lb), 64'(tbl[i].exp_bus));
            check($sformatf("vec%0d zflag", i), 64'(pif.Zflag), 64'(tbl[i].exp_z));
        end

        // Back-to-back mvi, add, mv with Run held: 2 + 4 + 2 cycles.
        t_start = $time;
        exec(3'd1, 6, 0, 16'h0003, lb);
        exec(3'd2, 6, 6, '0, lb);
        exec(3'd0, 7, 6, '0, lb);
        check("b2b cycles", 64'(($time - t_start) / 10), 64'd8);
        check("b2b r7", 64'(lb), 64'h0006);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            exec(3'($urandom_range(0, 7)), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                 imm, lb);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end

        // Reset during T2 of add R4,R5 aborts the write.
        exec(3'd1, 4, 0, 16'h0003, lb);
        exec(3'd1, 5, 0, 16'h0004, lb);
        pif.Run = 1'b1;
        pif.DIN = {7'd0, 3'd2, 3'd4, 3'd5};
        next_cycle();
        pif.Run = 1'b0;
        #1;
        check("abort t1 done", 64'(pif.Done), 64'd0);
        next_cycle();
        rst = 1'b1;
        #1;
        check("abort rst done", 64'(pif.Done), 64'd0);
        check("abort rst bus", 64'(pif.BusWires), 64'd0);
        next_cycle();
        check("abort held done", 64'(pif.Done), 64'd0);
        rst = 1'b0;
        model_reset();
        idle(2);
        exec(3'd0, 4, 4, '0, lb);
        check("abort r4", 64'(lb), 64'd0);
        exec(3'd4, 5, 5, '0, lb);
        check("abort r5", 64'(lb), 64'd0);

        // Wide instance: 0xFFFFFFFF + 1 wraps to zero.
        exec2(3'd1, 14, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, "w mvi r14");
        exec2(3'd1, 15, 0, 32'h0000_0001, 1, 32'h0000_0001, "w mvi r15");
        check("w zflag pre", 64'(pif2.Zflag), 64'd0);
        exec2(3'd2, 14, 15, '0, 3, 32'h0, "w add");
        check("w zflag", 64'(pif2.Zflag), 64'd1);
        exec2(3'd0, 14, 14, '0, 1, 32'h0, "w mv r14");
        exec2(3'd0, 13, 15, '0, 1, 32'h1, "w mv r13");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proc_param.md
# proc_param

Parametrised multicycle processor, the next generation of the team's 16-bit bus-based processor. It fetches one instruction word from `DIN` per `Run` request and executes it over 2–4 clock cycles on a shared `BusWires` bus. Register count and data width are generalised; the instruction set is extended with logic ops and a zero flag. It sits between the instruction/data source driving `DIN` and any consumer observing `BusWires`/`Done`.

## Interface
- `WIDTH`, 16: data width of registers, bus, ALU.
- `NREG`, 8: number of general registers R0..R(NREG-1); power of 2, 2..16. `RB` = clog2(NREG).
- Derived: instruction width `IW` = 3 + 2·RB; requires `WIDTH` ≥ `IW`.

- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `DIN`  in  WIDTH  instruction word (T0) or immediate (mvi, T1).
- `Run`  in  1  start request, sampled only in T0.
- `Done`  out  1  high during the final step of each instruction.
- `BusWires`  out  WIDTH  current bus value.
- `Zflag`  out  1  zero flag of last ALU result.

## Operation
- Instruction = `DIN[IW-1:0]`: opcode `[IW-1:IW-3]`, X = next RB bits, Y = low RB bits; `DIN[WIDTH-1:IW]` ignored.
- Opcodes: 000 mv Rx←Ry; 001 mvi Rx←DIN; 010 add Rx←Rx+Ry; 011 sub Rx←Rx−Ry; 100 and; 101 or; 110 mvnz (see Configuration); 111 nop.
- Step counter T0..T3 (2 bits). T0: if `Run`=1, IR←instruction, go T1; else stay T0.
- T1: mv — bus=Ry, Rx←bus, `Done`. mvi — bus=DIN, Rx←bus, `Done`. nop — bus=0, `Done`. ALU ops — bus=Rx, A←bus.
- T2 (ALU ops): bus=Ry, G←A op bus, Zflag←(result==0).
- T3 (ALU ops): bus=G, Rx←bus, `Done`.
- Step after `Done` is always T0.
- Arithmetic modulo 2^WIDTH; no carry/overflow outputs. X==Y legal (add R2,R2 doubles).
- Bus is a one-hot-select mux; exactly one source per cycle; 0 when no source selected (T0).
- `Run` ignored in T1–T3. `Run` high in the T0 following `Done` starts the next instruction immediately.

## Timing
- Reset (async assert, sync release): all Rn, A, G, IR, step←0, Zflag←0; `Done`=0, `BusWires`=0.
- Reset mid-instruction aborts; no register write completes; next cycle is T0.
- Latency from T0 accept to `Done`: mv/mvi/mvnz/nop 1 cycle (Done in T1); add/sub/and/or 3 cycles (Done in T3).
- Destination register visible on the edge ending the `Done` cycle.
- `Done` and `BusWires` are combinational from step/IR/registers; no combinational path from `Run` to `Done`.
- Zflag changes only on the T2→T3 edge of ALU ops.

## Configuration
- `PROC_PARAM_MVNZ_EN` defined: opcode 110 = mvnz; in T1 bus=Ry, Rx←bus only if Zflag==0; `Done` in T1 regardless.
- Not defined: opcode 110 decodes as nop (bus=0, no write, `Done` in T1). Zflag still maintained and output.

## Test plan
- Reset held 3 cycles with `Run`=1 -> `Done`=0, `BusWires`=0, all registers 0, step stays T0 after release until `Run` sampled.
- mvi R0,#0x0005 then mv R1,R0 (WIDTH=16, NREG=8) -> `Done` in 2nd cycle of each; R1=0x0005; bus shows 0x0005 in each T1.
- add R0,R1 with R0=0xFFFF, R1=0x0001 -> `Done` in T3, R0=0x0000, Zflag=1; sub R1,R1 -> R1=0, Zflag=1; and 0x00F0&0x0F0F -> 0x0000.
- mvnz R2,R3 with R3=0x1234: Zflag=1 -> R2 unchanged; Zflag=0 -> R2=0x1234; with macro undefined -> R2 never changes, `Done` in T1.
- `Run` held high continuously across mvi, add, mv -> back-to-back execution, one idle-free T0 fetch each, total 2+4+2 cycles.
- Reset asserted in T2 of add R4,R5 -> R4 stays 0, G=0, `Done` never asserted; WIDTH=32/NREG=16 rerun of scenario 3 with 0xFFFFFFFF+1 -> 0, Zflag=1.
